// File: rtl/mfcc_pack_pkg.sv
// Shared system configuration: MFCC feature geometry and the CONV1 input
// constants that the packed feature vector has to match.
package mfcc_pack_pkg;

  localparam int FEAT_BW    = 8;
  localparam int NUM_FEAT   = 13;
  localparam int NUM_FRAMES = 50;

  // First convolution layer consumes one MFCC vector per input column
  localparam int CONV1_IN_CH     = NUM_FEAT;
  localparam int CONV1_IN_LEN    = NUM_FRAMES;
  localparam int CONV1_VECTOR_BW = FEAT_BW * NUM_FEAT;

  localparam int VECTOR_BW = CONV1_VECTOR_BW;

  // Counter width for a 0..range-1 counter, never narrower than one bit
  function automatic int cnt_w(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/mfcc_pack_if.sv
// Coefficient stream in, packed vector stream out.
interface mfcc_pack_if
  import mfcc_pack_pkg::*;
#(
  parameter int FEAT_BW   = mfcc_pack_pkg::FEAT_BW,
  parameter int VECTOR_BW = mfcc_pack_pkg::VECTOR_BW
);
  logic [FEAT_BW-1:0]   data_i;
  logic                 valid_i;
  logic                 ready_o;
  logic [VECTOR_BW-1:0] data_o;
  logic                 valid_o;
  logic                 last_o;
  logic                 ready_i;

  // Block side
  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o, last_o
  );

  // Producer / accelerator side
  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o, last_o
  );
endinterface

// File: rtl/mfcc_pack.sv
// Packs NUM_FEAT serial coefficients into one vector for the recognition
// accelerator. Elements 0..NUM_FEAT-2 sit in an assembly register; the final
// element loads the output register directly, so assembly of the next vector
// continues while the output is stalled downstream.
module mfcc_pack
  import mfcc_pack_pkg::*;
#(
  parameter int FEAT_BW    = mfcc_pack_pkg::FEAT_BW,
  parameter int NUM_FEAT   = mfcc_pack_pkg::NUM_FEAT,
  parameter int NUM_FRAMES = mfcc_pack_pkg::NUM_FRAMES,
  parameter int VECTOR_BW  = FEAT_BW * NUM_FEAT
) (
  input logic       clk_i,
  input logic       rst_n_i,
  mfcc_pack_if.slave bus
);

  localparam int EW = cnt_w(NUM_FEAT);
  localparam int FW = cnt_w(NUM_FRAMES);

  localparam logic [EW-1:0] ELEM_LAST  = EW'(NUM_FEAT - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(NUM_FRAMES - 1);

  logic [EW-1:0]                        elem_cnt;
  logic [FW-1:0]                        frame_cnt;
  logic [NUM_FEAT-2:0][FEAT_BW-1:0]     asm_q;
  logic [VECTOR_BW-1:0]                 data_q;
  logic                                 valid_q;
  logic                                 last_q;
  logic                                 last_elem;
  logic                                 ready;
  logic                                 in_xfer;
  logic                                 out_xfer;
  logic                                 vec_done;

  // Only the closing element needs a free output register; the rest always
  // land in the assembly register. Independent of valid_i by construction.
  assign last_elem = (elem_cnt == ELEM_LAST);
  assign ready     = !last_elem || !valid_q || bus.ready_i;
  assign in_xfer   = bus.valid_i && ready;
  assign out_xfer  = valid_q && bus.ready_i;
  assign vec_done  = in_xfer && last_elem;

  assign bus.ready_o = ready;
  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.last_o  = last_q;

  // Element position within the vector being assembled
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     elem_cnt <= '0;
    else if (in_xfer) elem_cnt <= last_elem ? '0 : elem_cnt + 1'b1;
  end

  // Assembly register: element k in slot k, slot 0 ends up in the LSBs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      asm_q <= '0;
    end else if (in_xfer && !last_elem) begin
      for (int k = 0; k < NUM_FEAT - 1; k++)
        if (elem_cnt == EW'(k)) asm_q[k] <= bus.data_i;
    end
  end

  // Output register and frame tracking; a completing vector takes priority
  // over consumption so back-to-back vectors leave valid_o high
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      frame_cnt <= '0;
    end else if (vec_done) begin
      data_q    <= {bus.data_i, asm_q};
      valid_q   <= 1'b1;
      last_q    <= (frame_cnt == FRAME_LAST);
      frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
    end else if (out_xfer) begin
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end
  end

endmodule
